// File: rtl/single_cycle_cpu.sv
// Single-cycle MIPS subset CPU: fetch/decode/execute/mem/writeback complete in one core cycle.
// Latency: one instruction retires per rising clk edge; register and memory writes commit on that edge.
// Backpressure: none. The datapath never stalls. Ports: clk (rising edge), reset (async, active-low).
// Optional feature: define SINGLE_CYCLE_BNE_EN to decode opcode 0x05 (bne); otherwise it executes as a NOP.

// Register file: 32x32, two combinational read ports, one write port, $0 hard-wired to zero.
module single_cycle_cpu_rf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2,
    input  logic        i_we,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd
);
    logic [31:0] regfile [0:31];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regfile[i] <= '0;
        end else if (i_we && (i_wa != 5'd0)) begin
            regfile[i_wa] <= i_wd;
        end
    end

    assign o_rd1 = (i_ra1 == 5'd0) ? 32'd0 : regfile[i_ra1];
    assign o_rd2 = (i_ra2 == 5'd0) ? 32'd0 : regfile[i_ra2];
endmodule

// Word data RAM: combinational read, write on rising edge, cleared by async reset.
module single_cycle_cpu_dm #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wd,
    output logic [31:0]   o_rd
);
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (i_we) begin
            mem[i_addr] <= i_wd;
        end
    end

    assign o_rd = mem[i_addr];
endmodule

module single_cycle_cpu #(
    parameter int    IMEM_DEPTH = 64,
    parameter int    DMEM_DEPTH = 64,
    parameter string IMEM_FILE  = ""
) (
    input  logic clk,
    input  logic reset
);
    localparam int IW = $clog2(IMEM_DEPTH);
    localparam int DW = $clog2(DMEM_DEPTH);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    logic [31:0] r_pc;
    logic [31:0] r_imem [IMEM_DEPTH];

    // ROM contents: the Fibonacci program (t0..t4 = $8..$12).
    // Unused words stay zero, which decodes as a NOP.
    initial begin
        for (int i = 0; i < IMEM_DEPTH; i++) r_imem[i] = 32'h0;
        r_imem[0]  = 32'h20080000; // addi t0,0,0
        r_imem[1]  = 32'h20090001; // addi t1,0,1
        r_imem[2]  = 32'h200A0000; // addi t2,0,0
        r_imem[3]  = 32'h200B000A; // addi t3,0,10
        r_imem[4]  = 32'hAD480000; // sw   t0,0(t2)
        r_imem[5]  = 32'h01096020; // add  t4,t0,t1
        r_imem[6]  = 32'h01204020; // add  t0,t1,0
        r_imem[7]  = 32'h01804820; // add  t1,t4,0
        r_imem[8]  = 32'h214A0004; // addi t2,t2,4
        r_imem[9]  = 32'h216BFFFF; // addi t3,t3,-1
        r_imem[10] = 32'h11600001; // beq  t3,0,+1
        r_imem[11] = 32'h08000004; // j    4
        r_imem[12] = 32'h0800000C; // j    12 (halt)
    end

    logic [31:0] w_instr;
    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic [31:0] w_sext, w_pc4, w_rs_val, w_rt_val, w_alu_b, w_alu, w_mem_rd;
    logic        w_reg_we, w_dst_rd, w_use_imm, w_mem_we, w_mem_to_reg;
    logic        w_take_br, w_jump, w_rtype_ok;
    logic [31:0] w_pc_next;
    logic        w_unused;

    assign w_instr  = r_imem[r_pc[IW+1:2]];
    assign w_op     = w_instr[31:26];
    assign w_rs     = w_instr[25:21];
    assign w_rt     = w_instr[20:16];
    assign w_rd     = w_instr[15:11];
    assign w_funct  = w_instr[5:0];
    assign w_sext   = {{16{w_instr[15]}}, w_instr[15:0]};
    assign w_pc4    = r_pc + 32'd4;
    assign w_unused = ^w_instr[10:6];

    // R-type with an unknown funct must not write the register file.
    always_comb begin
        w_rtype_ok = 1'b0;
        w_alu      = 32'd0;
        if (w_op == OP_RTYPE) begin
            w_rtype_ok = 1'b1;
            case (w_funct)
                6'h20:   w_alu = w_rs_val + w_alu_b;
                6'h22:   w_alu = w_rs_val - w_alu_b;
                6'h24:   w_alu = w_rs_val & w_alu_b;
                6'h25:   w_alu = w_rs_val | w_alu_b;
                6'h2A:   w_alu = {31'd0, $signed(w_rs_val) < $signed(w_alu_b)};
                default: w_rtype_ok = 1'b0;
            endcase
        end else begin
            w_alu = w_rs_val + w_alu_b;   // addi / lw / sw address
        end
    end

    always_comb begin
        w_reg_we     = 1'b0;
        w_dst_rd     = 1'b0;
        w_use_imm    = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_to_reg = 1'b0;
        w_take_br    = 1'b0;
        w_jump       = 1'b0;
        case (w_op)
            OP_RTYPE: begin w_reg_we = w_rtype_ok; w_dst_rd = 1'b1; end
            OP_ADDI:  begin w_reg_we = 1'b1; w_use_imm = 1'b1; end
            OP_LW:    begin w_reg_we = 1'b1; w_use_imm = 1'b1; w_mem_to_reg = 1'b1; end
            OP_SW:    begin w_mem_we = 1'b1; w_use_imm = 1'b1; end
            OP_BEQ:   w_take_br = (w_rs_val == w_rt_val);
`ifdef SINGLE_CYCLE_BNE_EN
            OP_BNE:   w_take_br = (w_rs_val != w_rt_val);
`else
            OP_BNE:   w_take_br = 1'b0;
`endif
            OP_J:     w_jump = 1'b1;
            default:  ;
        endcase
    end

    assign w_alu_b = w_use_imm ? w_sext : w_rt_val;

    always_comb begin
        w_pc_next = w_pc4;
        if (w_jump)
            w_pc_next = {w_pc4[31:28], w_instr[25:0], 2'b00};
        else if (w_take_br)
            w_pc_next = w_pc4 + {w_sext[29:0], 2'b00};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_pc <= 32'd0;
        else        r_pc <= w_pc_next;
    end

    single_cycle_cpu_rf RF (
        .clk   (clk),
        .rst_n (reset),
        .i_ra1 (w_rs),
        .i_ra2 (w_rt),
        .o_rd1 (w_rs_val),
        .o_rd2 (w_rt_val),
        .i_we  (w_reg_we),
        .i_wa  (w_dst_rd ? w_rd : w_rt),
        .i_wd  (w_mem_to_reg ? w_mem_rd : w_alu)
    );

    single_cycle_cpu_dm #(.DEPTH(DMEM_DEPTH)) DM (
        .clk    (clk),
        .rst_n  (reset),
        .i_we   (w_mem_we),
        .i_addr (w_alu[DW+1:2]),
        .i_wd   (w_rt_val),
        .o_rd   (w_mem_rd)
    );
endmodule

// File: tb/tb_single_cycle_cpu.sv
// Bench for single_cycle_cpu: Fibonacci program, async reset mid-run, and table-driven custom programs.
// Latency: outputs sampled 1 ns after each rising edge.
// Backpressure: not applicable; the CPU free-runs.
module tb_single_cycle_cpu;
    logic clk;
    logic reset;

    int n_tests;
    int n_fail;

    single_cycle_cpu dut (
        .clk   (clk),
        .reset (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          prog;
        bit          is_mem;
        int          idx;
        logic [31:0] exp;
        string       name;
    } vec_t;

    logic [31:0] progs [4][6];
    vec_t        vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_fib(input string tag);
        logic [31:0] fib [10];
        fib = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
        for (int i = 0; i < 10; i++)
            check($sformatf("%s mem[%0d]", tag, i), dut.DM.mem[i], fib[i]);
        check({tag, " t0"}, dut.RF.regfile[8],  32'd55);
        check({tag, " t1"}, dut.RF.regfile[9],  32'd89);
        check({tag, " t2"}, dut.RF.regfile[10], 32'd40);
        check({tag, " t3"}, dut.RF.regfile[11], 32'd0);
        check({tag, " pc"}, dut.r_pc,           32'd48);
    endtask

    task automatic load_prog(input int p);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 64; i++) dut.r_imem[i] = 32'h0;
        for (int j = 0; j < 6; j++) dut.r_imem[j] = progs[p][j];
        @(negedge clk);
        reset = 1'b1;
        run_cycles(12);
    endtask

    initial begin
        int cur;
        logic [31:0] act;

        n_tests = 0;
        n_fail  = 0;

        // P0: slt / sub with negative operand
        progs[0] = '{32'h2001FFFB, 32'h20020003, 32'h0022182A, 32'h00412022, 32'h0, 32'h0};
        // P1: writes to $0 are dropped
        progs[1] = '{32'h20000007, 32'hAC000000, 32'h8C050000, 32'h0, 32'h0, 32'h0};
        // P2: sw then lw next cycle, misaligned lw, bad opcode and bad funct as NOPs
        progs[2] = '{32'h2001004D, 32'hAC010008, 32'h8C060008, 32'h8C07000B, 32'hFC01FFFF, 32'h0000083F};
        // P3: bne skips the next instruction only when the macro is defined
        progs[3] = '{32'h20010001, 32'h14200001, 32'h20020009, 32'h20030004, 32'h0, 32'h0};

        vecs[0]  = '{0, 1'b0, 3, 32'd1,        "slt $3"};
        vecs[1]  = '{0, 1'b0, 4, 32'd8,        "sub $4"};
        vecs[2]  = '{0, 1'b0, 1, 32'hFFFFFFFB, "addi neg $1"};
        vecs[3]  = '{0, 1'b0, 2, 32'd3,        "addi $2"};
        vecs[4]  = '{1, 1'b0, 0, 32'd0,        "$0 stays 0"};
        vecs[5]  = '{1, 1'b1, 0, 32'd0,        "sw $0 mem[0]"};
        vecs[6]  = '{1, 1'b0, 5, 32'd0,        "lw $5"};
        vecs[7]  = '{2, 1'b1, 2, 32'd77,       "sw mem[2]"};
        vecs[8]  = '{2, 1'b0, 6, 32'd77,       "lw after sw $6"};
        vecs[9]  = '{2, 1'b0, 7, 32'd77,       "misaligned lw $7"};
        vecs[10] = '{2, 1'b0, 1, 32'd77,       "nop ops keep $1"};
        vecs[11] = '{3, 1'b0, 1, 32'd1,        "bne prog $1"};
`ifdef SINGLE_CYCLE_BNE_EN
        vecs[12] = '{3, 1'b0, 2, 32'd0,        "bne skip $2"};
`else
        vecs[12] = '{3, 1'b0, 2, 32'd9,        "bne nop $2"};
`endif
        vecs[13] = '{3, 1'b0, 3, 32'd4,        "bne prog $3"};

        // Reset window: everything zero while reset is low
        reset = 1'b0;
        #12;
        check("reset pc", dut.r_pc, 32'd0);
        check("reset t0", dut.RF.regfile[8], 32'd0);
        check("reset mem[0]", dut.DM.mem[0], 32'd0);
        #8;
        reset = 1'b1;

        run_cycles(1);
        check("edge1 t0", dut.RF.regfile[8], 32'd0);
        check("edge1 pc", dut.r_pc, 32'd4);
        run_cycles(3);
        check("edge4 t0", dut.RF.regfile[8],  32'd0);
        check("edge4 t1", dut.RF.regfile[9],  32'd1);
        check("edge4 t2", dut.RF.regfile[10], 32'd0);
        check("edge4 t3", dut.RF.regfile[11], 32'd10);
        check("edge4 pc", dut.r_pc,           32'd16);
        run_cycles(96);
        check_fib("run1");

        // Mid-run async reset at cycle 30: state clears without a clock edge
        @(negedge clk);
        reset = 1'b0;
        #1;
        @(negedge clk);
        reset = 1'b1;
        run_cycles(30);
        check("pre-reset mem[1]", dut.DM.mem[1], 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async pc",      dut.r_pc,           32'd0);
        check("async t1",      dut.RF.regfile[9],  32'd0);
        check("async t2",      dut.RF.regfile[10], 32'd0);
        check("async mem[1]",  dut.DM.mem[1],      32'd0);
        @(posedge clk);
        #1;
        check("held pc", dut.r_pc, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_cycles(100);
        check_fib("rerun");

        // Table-driven custom programs
        cur = -1;
        for (int r = 0; r < 14; r++) begin
            if (vecs[r].prog != cur) begin
                load_prog(vecs[r].prog);
                cur = vecs[r].prog;
            end
            act = vecs[r].is_mem ? dut.DM.mem[vecs[r].idx] : dut.RF.regfile[vecs[r].idx];
            check(vecs[r].name, act, vecs[r].exp);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
